// File: rtl/pc_fetch_unit_if.sv
// Signal bundle between the fetch unit, the next-PC logic, the instruction bus and ID.
// The fetch unit takes the master side; the surrounding pipeline and memory take the slave side.
interface pc_fetch_unit_if;
    logic [31:0] npc;
    logic        jump_taken;
    logic        id_allowin;
    logic [31:0] if_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_inst;

    modport master (
        input  npc,
        input  jump_taken,
        input  id_allowin,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata,
        output if_pc,
        output inst_req,
        output inst_addr,
        output if_valid,
        output if_inst
    );

    modport slave (
        output npc,
        output jump_taken,
        output id_allowin,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata,
        input  if_pc,
        input  inst_req,
        input  inst_addr,
        input  if_valid,
        input  if_inst
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one instruction fetch at a time over a
// request/addr_ok/data_ok bus and hands the result to ID; redirects cancel in-flight fetches.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input logic             clk,
    input logic             resetn,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    // Set while the outstanding response belongs to an address abandoned by a redirect
    logic        cancel_q, cancel_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        cancel_d = cancel_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end

            StReq: begin
                if (bus.jump_taken) begin
                    pc_d = bus.npc;
                end
                if (bus.inst_addr_ok) begin
                    state_d  = StWait;
                    cancel_d = bus.jump_taken;
                end
            end

            StWait: begin
                if (bus.inst_data_ok) begin
                    cancel_d = 1'b0;
                    if (bus.jump_taken || cancel_q) begin
                        state_d = StReq;
                    end else begin
                        inst_d  = bus.inst_rdata;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                    if (bus.jump_taken) begin
                        pc_d = bus.npc;
                    end
                end else if (bus.jump_taken) begin
                    cancel_d = 1'b1;
                    pc_d     = bus.npc;
                end
            end

            StHold: begin
                // A redirect and a normal hand-off both load npc; only the former drops the instruction
                if (bus.jump_taken || bus.id_allowin) begin
                    pc_d    = bus.npc;
                    valid_d = 1'b0;
                    state_d = StReq;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.if_pc     = pc_q;
    assign bus.inst_addr = pc_q;
    assign bus.inst_req  = (state_q == StReq);
    assign bus.if_valid  = valid_q;
    assign bus.if_inst   = inst_q;

    a_valid_only_in_hold : assert property (
        @(posedge clk) disable iff (!resetn) valid_q == (state_q == StHold)
    );

    a_cancel_only_in_wait : assert property (
        @(posedge clk) disable iff (!resetn) cancel_q |-> (state_q == StWait)
    );

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the next-PC interface: holds the architectural fetch PC and drives it to the next-PC logic as `if_pc`.
- Loads `npc` on sequential advance or on a taken jump.
- Issues instruction fetches over an SRAM-like request/addr_ok/data_ok bus and presents the fetched instruction to ID with a valid/allowin handshake.
- Cancels in-flight fetches on redirect.

Parameters:
- RESET_PC, 32'h1c00_0000, fetch address after reset.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- npc  in  32  next PC from the next-PC logic (pc+4, or jump target when jump_taken)
- jump_taken  in  1  one-cycle redirect pulse from ID; npc holds the target that cycle
- id_allowin  in  1  ID can accept an instruction this cycle
- if_pc  out  32  current fetch PC; PC of the held instruction while if_valid=1
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address, always equal to if_pc
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data returned this cycle
- inst_rdata  in  32  returned instruction
- if_valid  out  1  if_inst/if_pc valid for ID
- if_inst  out  32  registered instruction

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, if_pc=RESET_PC, inst_req=0, if_valid=0, if_inst=0, cancel=0.
  - The instruction bus shares resetn, so no transaction survives reset.
  - Reset mid-fetch discards everything; fetch restarts at RESET_PC.
- States: IDLE, REQ, WAIT, HOLD. At most one outstanding request.
- IDLE: one cycle after resetn release, then -> REQ. No request issued.
- REQ: inst_req=1.
  - inst_addr_ok=1 -> WAIT.
  - The address may change while addr_ok is not yet seen; this happens only on redirect.
- WAIT: inst_req=0.
  - On inst_data_ok with cancel=0: if_inst<=inst_rdata, -> HOLD.
  - On inst_data_ok with cancel=1: drop the data, cancel<=0, -> REQ.
- HOLD: if_valid=1.
  - On id_allowin=1: if_pc<=npc, if_valid<=0, -> REQ.
  - Handshake completes in the cycle with if_valid & id_allowin.
- jump_taken handling (if_pc<=npc in every state except IDLE; priority over sequential advance):
  - REQ, addr_ok=0: stay REQ; the next request uses the target.
  - REQ, addr_ok=1: old address already accepted; -> WAIT with cancel<=1.
  - WAIT, data_ok=0: cancel<=1, stay WAIT.
  - WAIT, data_ok=1: drop data, cancel stays 0, -> REQ.
  - HOLD: drop the held instruction, if_valid<=0, -> REQ. Simultaneous id_allowin is ignored; ID receives no instruction that cycle.
  - IDLE: ignored.
- Spurious inst_data_ok in IDLE/REQ/HOLD and spurious inst_addr_ok outside REQ are ignored.
- Minimum per-instruction latency: 3 cycles (REQ, WAIT, HOLD) with zero-wait bus and id_allowin=1.
- Width rules:
  - if_pc is taken verbatim from npc; no alignment correction.
  - Wrap from 32'hffff_fffc to 0 is the next-PC logic's concern.
- All outputs are registered except inst_req and inst_addr, which are decoded from state and if_pc.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release.
  - During reset: if_pc=32'h1c000000, inst_req=0, if_valid=0.
  - inst_req=1 on the 2nd cycle after release.
- Sequential fetch, zero-wait bus (addr_ok same cycle, data_ok next), id_allowin=1, npc=if_pc+4:
  - ID receives 32'h1c000000, 32'h1c000004, 32'h1c000008, one instruction every 3 cycles, with matching rdata.
- Stall: id_allowin=0 for 5 cycles while in HOLD.
  - if_valid stays 1; if_inst and if_pc stay stable; inst_req=0.
  - Release -> if_pc advances to +4.
- Redirect in WAIT: jump_taken=1 with npc=32'h1c000100, data_ok 2 cycles later with rdata=32'hdeadbeef.
  - Data dropped; if_valid never rises for it.
  - Next request addr=32'h1c000100.
- Redirect coincident with addr_ok in REQ:
  - Next data_ok is discarded.
  - A new request to the target is issued; its instruction is delivered.
- Redirect in HOLD with id_allowin=1 the same cycle, npc=32'h1c000200:
  - No handshake counted; if_valid=0 next cycle.
  - The following request addr=32'h1c000200.
